// File: rtl/dmem_resp.sv
// dmem_resp: single-outstanding data-memory responder; ack arrives WAIT+1 cycles after capture.
// Define DMEM_RESP_CNT_EN to build saturating completed-read/write counters.
module dmem_resp #(
   parameter int WAIT  = 1,
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        memrw,
   input  logic [7:0]  addr,
   input  logic [31:0] dataw,
   output logic        ack,
   output logic        err,
   output logic [31:0] datar,
   output logic        busy,
   output logic [15:0] rd_cnt,
   output logic [15:0] wr_cnt
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rw_q;
   logic [7:0]  addr_q;
   logic [31:0] wdat_q;
   logic        ack_q, err_q;
   logic [31:0] datar_q;
   logic [31:0] mem [DEPTH];
   logic        cap, done, bad;
   assign cap  = state_q == S_IDLE && req;
   assign done = state_q == S_RESP;
   assign bad  = {1'b0, addr_q} >= 9'(DEPTH);
   always_comb begin
      state_d = cap ? ((WAIT > 0) ? S_WAIT : S_RESP)
              : state_q == S_WAIT ? (cnt_q == 4'd0 ? S_RESP : S_WAIT)
              : done ? S_IDLE : state_q;
      cnt_d   = cap ? ((WAIT > 0) ? 4'(WAIT - 1) : 4'd0)
              : (state_q == S_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
   end
   // ack/err/datar are registered off RESP so they rise on the edge that leaves it
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         datar_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= done;
         err_q   <= done && bad;
         if (done && !rw_q) datar_q <= bad ? 32'h0 : mem[addr_q[AW-1:0]];
      end
   always_ff @(posedge clk)
      if (cap) begin
         rw_q   <= memrw;
         addr_q <= addr;
         wdat_q <= dataw;
      end
   always_ff @(posedge clk)
      if (done && rw_q && !bad) mem[addr_q[AW-1:0]] <= wdat_q;
`ifdef DMEM_RESP_CNT_EN
   logic [15:0] rd_cnt_q, wr_cnt_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rd_cnt_q <= 16'h0;
         wr_cnt_q <= 16'h0;
      end else if (done && !bad) begin
         if (!rw_q && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
         if (rw_q && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
   assign rd_cnt = rd_cnt_q;
   assign wr_cnt = wr_cnt_q;
`else
   assign rd_cnt = 16'h0;
   assign wr_cnt = 16'h0;
`endif
   assign ack   = ack_q;
   assign err   = err_q;
   assign datar = datar_q;
   assign busy  = state_q != S_IDLE;
endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
- REQ-001 Parameter WAIT, default 1: wait states inserted between request capture and response (legal 0..15).
- REQ-002 Parameter DEPTH, default 256: number of implemented 32-bit words (legal 1..256).
- REQ-003 clk  input  1  single clock; all state changes on rising edge.
- REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- REQ-005 req  input  1  core request strobe; sampled only in IDLE.
- REQ-006 memrw  input  1  access type: 1 = write, 0 = read.
- REQ-007 addr  input  8  word address from core.
- REQ-008 dataw  input  32  write data from core.
- REQ-009 ack  output  1  one-cycle response pulse; transaction complete.
- REQ-010 err  output  1  qualifies ack; 1 = address >= DEPTH.
- REQ-011 datar  output  32  read data; valid when ack=1 and memrw of captured request was 0.
- REQ-012 busy  output  1  1 while a transaction is held (WAIT or RESP state).
- REQ-013 rd_cnt  output  16  completed-read counter (see Configuration).
- REQ-014 wr_cnt  output  16  completed-write counter (see Configuration).

Function
- REQ-015 FSM states IDLE, WAIT, RESP; the block SHALL hold exactly one transaction at a time.
- REQ-016 IDLE: req=1 at a rising edge captures memrw, addr, dataw into internal registers; next state WAIT if WAIT>0, else RESP.
- REQ-017 IDLE with req=0: stay IDLE; no register other than ack/err changes.
- REQ-018 WAIT: 4-bit down-counter loaded with WAIT-1 on capture; decrement each cycle; go to RESP when counter = 0.
- REQ-019 RESP: ack=1 for exactly one cycle, then IDLE unconditionally.
- REQ-020 Latency: ack high WAIT+1 cycles after the capturing edge; back-to-back requests accepted every WAIT+2 cycles.
- REQ-021 req, memrw, addr, dataw SHALL be ignored while busy=1; changes mid-transaction have no effect.
- REQ-022 Write: storage word at captured addr SHALL be updated on the same edge that raises ack; not before.
- REQ-023 Read: datar SHALL be loaded with storage word at captured addr on the edge that raises ack, and SHALL hold until the next read completes.
- REQ-024 Address >= DEPTH: ack with err=1; no storage write; datar loaded with 32'h0000_0000.
- REQ-025 err SHALL be 0 whenever ack=0.
- REQ-026 Read of a word written by the immediately preceding transaction SHALL return the new value.

Reset
- REQ-027 rst=0 SHALL immediately force state IDLE, ack=0, err=0, busy=0, datar=0, wait counter=0, rd_cnt=0, wr_cnt=0.
- REQ-028 Storage array SHALL NOT be reset; contents undefined until written.
- REQ-029 Reset during WAIT or RESP aborts the transaction: no storage write, no ack, no counter update.
- REQ-030 First request is sampled on the first rising edge after rst returns to 1.

Configuration
- REQ-031 Macro DMEM_RESP_CNT_EN: when defined, rd_cnt increments on each error-free read ack and wr_cnt on each error-free write ack; both saturate at 16'hFFFF.
- REQ-032 When DMEM_RESP_CNT_EN is undefined, rd_cnt and wr_cnt SHALL be constant 0 and no counter flops SHALL be built; all other behaviour identical.

Verification
- REQ-033 WAIT=1: write addr 8'h10 data 32'hDEADBEEF, then read 8'h10 -> each ack 2 cycles after capture, datar=32'hDEADBEEF, err=0.
- REQ-034 WAIT=0: back-to-back reads held with req=1 -> ack every 2 cycles, busy high between, inputs changed mid-transaction ignored.
- REQ-035 DEPTH=64: write 8'h40 data 32'h12345678, then read 8'h40 -> ack with err=1, datar=0; word 8'h00 unchanged.
- REQ-036 WAIT=3: write 8'h05 data 32'hA5A5A5A5, assert rst=0 two cycles after capture -> no ack, busy=0 immediately, later read of 8'h05 returns prior value.
- REQ-037 DMEM_RESP_CNT_EN defined: 3 good reads, 2 good writes, 1 errored read -> rd_cnt=3, wr_cnt=2; undefined -> both 0.
- REQ-038 DMEM_RESP_CNT_EN defined, force wr_cnt to 16'hFFFE, perform 3 writes -> wr_cnt=16'hFFFF, no wrap.
